// File: rtl/lsu_mem_ctrl.sv
// Purpose: RV32I load/store unit owning a byte-addressed, word-organised data memory.
// Latency: stores and faulted accesses respond 1 cycle after acceptance, loads READ_LAT cycles after.
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready.
module lsu_mem_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    // Counter value on which WAIT hands over to RESP (unused when READ_LAT is 1).
    localparam logic [1:0] CNT_LAST = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [1:0]          cnt;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                illegal;
    logic                range_err;
    logic                misal;
    logic [1:0]          fault_c;
    logic                wr_en;
    logic [3:0]          be;
    logic [31:0]         wlane;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && (state == IDLE);

    // Classify the incoming request; illegal beats range beats misaligned.
    always_comb begin
        illegal   = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                           : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111));
        range_err = (req_addr[31:ADDR_W] != '0);
        misal     = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (illegal)        fault_c = 2'b11;
        else if (range_err) fault_c = 2'b10;
        else if (misal)     fault_c = 2'b01;
        else                fault_c = 2'b00;
    end

    // Byte enables and lane-replicated store data for the accepting edge.
    always_comb begin
        be    = 4'b0000;
        wlane = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be[req_addr[1:0]] = 1'b1;
                wlane             = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Writes are suppressed while reset is held so a half-presented store cannot land.
    assign wr_en = accept && req_we && (fault_c == 2'b00) && rst_n;

    // Data memory: byte-enabled write on the accepting edge, contents never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[req_addr[ADDR_W-1:2]][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    // Align the addressed byte/halfword to bit 0 and extend according to funct3.
    function automatic logic [31:0] load_result(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_result = {{24{s[7]}}, s[7:0]};
            3'b001:  load_result = {{16{s[15]}}, s[15:0]};
            3'b100:  load_result = {24'h0, s[7:0]};
            3'b101:  load_result = {16'h0, s[15:0]};
            default: load_result = s;
        endcase
    endfunction

    // Transaction FSM with registered response data and fault code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            rsp_rdata <= 32'h0;
            rsp_fault <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr[ADDR_W-1:0];
                        cnt      <= 2'd0;
                        if ((fault_c != 2'b00) || req_we) begin
                            rsp_rdata <= 32'h0;
                            rsp_fault <= fault_c;
                            state     <= RESP;
                        end else if (READ_LAT == 1) begin
                            rsp_rdata <= load_result(mem[req_addr[ADDR_W-1:2]], req_addr[1:0], req_funct3);
                            rsp_fault <= 2'b00;
                            state     <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        rsp_rdata <= load_result(mem[addr_q[ADDR_W-1:2]], addr_q[1:0], funct3_q);
                        rsp_fault <= 2'b00;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a byte-level memory model.
module tb_lsu_mem_ctrl;

    localparam int ADDR_W = 12;
    localparam int LAT    = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One complete transaction; lat counts falling edges from acceptance to rsp_valid.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int stall,
                       output logic [31:0] rd, output logic [1:0] ft, output int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = (stall == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) chk("rsp_timeout", {31'h0, rsp_valid}, 32'h1);
        rd = rsp_rdata;
        ft = rsp_fault;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_rdata", rsp_rdata, rd);
            chk("stall_valid", {31'h0, rsp_valid}, 32'h1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rsp", {31'h0, req_ready}, 32'h1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  mb [64];

    initial begin
        logic [31:0] rd, held_rd;
        logic [1:0]  ft;
        int          lat, n;

        vecs.push_back('{1'b1, 3'b010, 32'h4,    32'hF0F0F0F0, 32'h00000000, 2'b00, 1});
        vecs.push_back('{1'b0, 3'b010, 32'h4,    32'h0,        32'hF0F0F0F0, 2'b00, LAT});
        vecs.push_back('{1'b0, 3'b001, 32'h4,    32'h0,        32'hFFFFF0F0, 2'b00, LAT});
        vecs.push_back('{1'b0, 3'b101, 32'h6,    32'h0,        32'h0000F0F0, 2'b00, LAT});
        vecs.push_back('{1'b0, 3'b000, 32'h5,    32'h0,        32'hFFFFFFF0, 2'b00, LAT});
        vecs.push_back('{1'b0, 3'b100, 32'h7,    32'h0,        32'h000000F0, 2'b00, LAT});
        vecs.push_back('{1'b1, 3'b010, 32'h8,    32'h00000000, 32'h00000000, 2'b00, 1});
        vecs.push_back('{1'b1, 3'b001, 32'hA,    32'hFFFFFFFF, 32'h00000000, 2'b00, 1});
        vecs.push_back('{1'b1, 3'b000, 32'h8,    32'hFFAFFFAF, 32'h00000000, 2'b00, 1});
        vecs.push_back('{1'b0, 3'b010, 32'h8,    32'h0,        32'hFFFF00AF, 2'b00, LAT});
        vecs.push_back('{1'b0, 3'b010, 32'h6,    32'h0,        32'h00000000, 2'b01, 1});
        vecs.push_back('{1'b1, 3'b001, 32'h4001, 32'h1234,     32'h00000000, 2'b10, 1});
        vecs.push_back('{1'b0, 3'b011, 32'h4,    32'h0,        32'h00000000, 2'b11, 1});
        vecs.push_back('{1'b0, 3'b011, 32'h5001, 32'h0,        32'h00000000, 2'b11, 1});
        vecs.push_back('{1'b1, 3'b100, 32'h4,    32'h0,        32'h00000000, 2'b11, 1});
        vecs.push_back('{1'b0, 3'b010, 32'h4,    32'h0,        32'hF0F0F0F0, 2'b00, LAT});

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_fault", {30'h0, rsp_fault}, 32'h0);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, 0, rd, ft, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d_fault", i), {30'h0, ft}, {30'h0, vecs[i].ft});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Response held off for 5 cycles while another request waits
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_we = 1'b1; req_addr = 32'hC; req_wdata = 32'h12345678;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk("hold_lat", n, LAT);
        held_rd = rsp_rdata;
        chk("hold_rdata", held_rd, 32'hF0F0F0F0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
            chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("hold_rsp_rdata", rsp_rdata, held_rd);
            chk("hold_rsp_fault", {30'h0, rsp_fault}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_hold_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("queued_store_valid", {31'h0, rsp_valid}, 32'h1);
        chk("queued_store_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        txn(1'b0, 3'b010, 32'hC, 32'h0, 0, rd, ft, lat);
        chk("queued_store_readback", rd, 32'h12345678);

        // Reset while a load sits in WAIT
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_async_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        txn(1'b0, 3'b010, 32'h4, 32'h0, 0, rd, ft, lat);
        chk("rst_reload_rdata", rd, 32'hF0F0F0F0);
        chk("rst_reload_lat", lat, LAT);

        // Randomized traffic against a byte-array model
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            txn(1'b1, 3'b010, 32'(w * 4), d, 0, rd, ft, lat);
            for (int b = 0; b < 4; b++) mb[w*4 + b] = d[8*b +: 8];
        end
        for (int i = 0; i < 150; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wd, exp_rd;
            logic [1:0]  exp_ft;
            int          sz, exp_lat, stall;
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(ADDR_W, 31));
            wd    = $urandom;
            stall = $urandom_range(0, 2);
            sz    = 1 << f3[1:0];
            exp_rd = 32'h0;
            if (we ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
                exp_ft = 2'b11;
            else if ((addr >> ADDR_W) != 0)
                exp_ft = 2'b10;
            else if ((addr % sz) != 0)
                exp_ft = 2'b01;
            else
                exp_ft = 2'b00;
            exp_lat = (exp_ft == 2'b00 && !we) ? LAT : 1;
            if (exp_ft == 2'b00) begin
                if (we) begin
                    for (int b = 0; b < sz; b++) mb[addr + b] = wd[8*b +: 8];
                end else begin
                    for (int b = 0; b < sz; b++) exp_rd = exp_rd | (32'(mb[addr + b]) << (8 * b));
                    if (!f3[2] && sz < 4 && exp_rd[8*sz - 1])
                        exp_rd = exp_rd | ~((32'h1 << (8 * sz)) - 32'h1);
                end
            end
            txn(we, f3, addr, wd, stall, rd, ft, lat);
            chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rnd%0d_fault", i), {30'h0, ft}, {30'h0, exp_ft});
            chk($sformatf("rnd%0d_lat", i), lat, exp_lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Parametrised load/store unit for the RISC-V core. It owns a byte-addressed, word-organised data memory and executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW through a valid/ready request port and a valid/ready response port. Memory read latency is configurable, and the unit flags illegal, out-of-range and misaligned accesses. It sits between the execute stage (address from ALU, funct3 from decode) and the writeback mux.

## Interface
- ADDR_W, 12: byte-address width that is decoded; memory holds 2**(ADDR_W-2) 32-bit words.
- READ_LAT, 1: load latency in cycles from acceptance to rsp_valid; legal range 1..4.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and faults.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE), driven combinationally.
- Accept on the rising edge where state is IDLE and req_valid=1. The unit latches we, funct3, addr and wdata, then checks for faults in this priority order:
  - illegal: a store with funct3[2]=1 or funct3[1:0]=11, or a load with funct3 in {011,110,111};
  - range: req_addr[31:ADDR_W] != 0;
  - misaligned: a halfword access with addr[0]=1, or a word access with addr[1:0] != 0.
- Faulted access: no memory write. Go to RESP with rsp_rdata=0 and the fault code set.
- Store: the byte-enabled write happens on the accepting edge.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Go to RESP with rsp_rdata=0 and rsp_fault=00.
- Load: go to WAIT and count READ_LAT-1 further cycles; with READ_LAT=1, go to RESP directly.
- Load result on entering RESP: select the word at addr[ADDR_W-1:2], then shift right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- RESP: rsp_valid=1; rsp_rdata and rsp_fault are held stable. On an edge with rsp_ready=1, go to IDLE.
- One transaction is outstanding at a time. Requests are not accepted in WAIT or RESP.
- The memory array is not reset; its contents are undefined until written.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=00, latency counter 0.
- Reset asserted mid-operation: return immediately to IDLE and drop any pending response.
  - A store that was already accepted stays written.
  - A load in WAIT is discarded.
- Store or faulted access: rsp_valid rises 1 cycle after acceptance.
- Load: rsp_valid rises READ_LAT cycles after acceptance.
- If rsp_ready is already high when rsp_valid rises, the response completes on the next edge. req_ready is high the cycle after that.
- Back-to-back peak throughput is therefore one store per 2 cycles and one load per READ_LAT+1 cycles.
- A load issued immediately after a store to the same word returns the newly written data.
- rsp_ready held low keeps the unit in RESP indefinitely with all outputs stable.

## Test plan
- Reset, then SW 0x4 data F0F0F0F0, then LW 0x4 -> store rsp 00000000/00; load rsp F0F0F0F0/00 exactly READ_LAT cycles after acceptance (run with READ_LAT=1 and 3).
- After the first scenario: LH 0x4 -> FFFFF0F0; LHU 0x6 -> 0000F0F0; LB 0x5 -> FFFFFFF0; LBU 0x7 -> 000000F0.
- SW 0x8 data 00000000, then SH 0xA data FFFFFFFF, then SB 0x8 data FFAFFFAF, then LW 0x8 -> FFFF00AF.
- LW 0x6 -> fault 01, memory unchanged. SH 0x4001 (ADDR_W=12) -> fault 10. Load funct3=011 -> fault 11. All three have rdata 0 and a 1-cycle response.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 throughout -> req_ready stays 0 and rsp_* stay stable; the next request is accepted one cycle after the rsp_ready handshake.
- Assert rst_n=0 during WAIT (READ_LAT=4) -> rsp_valid stays 0 and req_ready=1 asynchronously. After release, an LW of the same address returns the correct data.
